// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// One unsigned-by-signed scaled multiplier shared by NUM_REQ requesters.
// A round-robin grant picks the operands that go into stage 1. Stage 2 holds
// the shifted and narrowed product, together with the id of the requester
// that owns it.
// Optional feature macro: MUL_ARB_RESULT_SAT_EN. When it is defined, the
// result saturates instead of wrapping, and the res_sat port is added.
module mul_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_SCALE = 8,
  localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         arst_n_in,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [OUT_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic                         busy
`ifdef MUL_ARB_RESULT_SAT_EN
  ,
  output logic                         res_sat
`endif
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic                 s1_valid_q, s1_valid_d;
  logic [A_WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [B_WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [ID_WIDTH-1:0]  s1_id_q, s1_id_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;

  logic                 res_valid_q, res_valid_d;
  logic [OUT_WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_WIDTH-1:0]  res_id_q, res_id_d;

  logic                 stall, s2_load, s1_adv, accept;
  logic                 grant_found;
  logic [ID_WIDTH-1:0]  grant_idx;
  int                   scan_idx;

  logic signed [P_WIDTH-1:0] a_ext, b_ext, prod, shifted;
  logic [OUT_WIDTH-1:0]      res_next;

  assign stall   = res_valid_q && !res_ready;
  assign s2_load = s1_valid_q && !stall;
  assign s1_adv  = !s1_valid_q || s2_load;

  // Round-robin scan: the first valid requester at or above rr_ptr, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(scan_idx);
      end
    end
  end

  assign accept    = s1_adv && grant_found;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;

  // Stage 1 next state: capture the granted operands and move priority past the winner
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (s1_adv) begin
      s1_valid_d = accept;
    end
    if (accept) begin
      s1_a_d  = req_a[grant_idx*A_WIDTH +: A_WIDTH];
      s1_b_d  = req_b[grant_idx*B_WIDTH +: B_WIDTH];
      s1_id_d = grant_idx;
      rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

  // Stage 1 operand and priority registers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // a is an unsigned magnitude and b is a signed weight. The product of the
  // two always fits in P_WIDTH signed bits.
  assign a_ext   = signed'({{B_WIDTH{1'b0}}, s1_a_q});
  assign b_ext   = signed'({{A_WIDTH{s1_b_q[B_WIDTH-1]}}, s1_b_q});
  assign prod    = a_ext * b_ext;
  assign shifted = prod >>> OUT_SCALE;

`ifdef MUL_ARB_RESULT_SAT_EN
  localparam int X_WIDTH = (P_WIDTH > OUT_WIDTH) ? P_WIDTH : OUT_WIDTH;

  logic signed [X_WIDTH-1:0] shifted_x, sat_max, sat_min;
  logic                      sat_next;
  logic                      res_sat_q, res_sat_d;

  assign shifted_x = X_WIDTH'(shifted);
  assign sat_max   = signed'({{(X_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  assign sat_min   = signed'({{(X_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  // Clamp the shifted product to the signed range of OUT_WIDTH and flag when the clamp fires
  always_comb begin
    res_next = OUT_WIDTH'(shifted_x);
    sat_next = 1'b0;
    if (shifted_x > sat_max) begin
      res_next = OUT_WIDTH'(sat_max);
      sat_next = 1'b1;
    end else if (shifted_x < sat_min) begin
      res_next = OUT_WIDTH'(sat_min);
      sat_next = 1'b1;
    end
  end

  assign res_sat_d = s2_load ? sat_next : res_sat_q;

  // The saturation flag travels with the result in stage 2
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      res_sat_q <= 1'b0;
    end else begin
      res_sat_q <= res_sat_d;
    end
  end

  assign res_sat = res_sat_q;
`else
  // Narrow by keeping the low bits. Values out of range wrap around.
  assign res_next = OUT_WIDTH'(shifted);
`endif

  // Stage 2 next state: load from stage 1 unless stalled; retire on consume
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    if (s2_load) begin
      res_valid_d = 1'b1;
      res_data_d  = res_next;
      res_id_d    = s1_id_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Stage 2 result registers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = s1_valid_q || res_valid_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter. It uses a default-parameter instance,
// plus a narrow instance (OUT_WIDTH=8, OUT_SCALE=0) for the wrap/saturation vectors.
module tb_mul_share_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int BW = 8;
  localparam int OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst_n_in = 1'b0;
  logic [NR-1:0]     req_valid, req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*BW-1:0]  req_b;
  logic              res_valid, res_ready;
  logic [OW-1:0]     res_data;
  logic [1:0]        res_id;
  logic              busy;

  logic [NR-1:0]     w_req_valid, w_req_ready;
  logic [NR*AW-1:0]  w_req_a;
  logic [NR*BW-1:0]  w_req_b;
  logic              w_res_valid, w_res_ready;
  logic [7:0]        w_res_data;
  logic [1:0]        w_res_id;
  logic              w_busy;
`ifdef MUL_ARB_RESULT_SAT_EN
  logic              res_sat, w_res_sat;
`endif

  int errors = 0;
  int checks = 0;

  mul_share_arbiter dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
`ifdef MUL_ARB_RESULT_SAT_EN
    , .res_sat(res_sat)
`endif
  );

  mul_share_arbiter #(.OUT_WIDTH(8), .OUT_SCALE(0)) dut_w (
    .clk(clk), .arst_n_in(arst_n_in),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_a(w_req_a), .req_b(w_req_b),
    .res_valid(w_res_valid), .res_ready(w_res_ready), .res_data(w_res_data), .res_id(w_res_id),
    .busy(w_busy)
`ifdef MUL_ARB_RESULT_SAT_EN
    , .res_sat(w_res_sat)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    arst_n_in = 1'b0;
    req_valid = '0;
    w_req_valid = '0;
    tick();
    arst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    arst_n_in = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    w_req_valid = '0; w_req_a = '0; w_req_b = '0; w_res_ready = 1'b1;
    tick(); tick();
    checks++;
    if (res_valid !== 1'b0 || res_data !== 16'h0 || res_id !== 2'd0 || busy !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h id=%0d busy=%b ready=%b, required 0/0000/0/0/0000",
               res_valid, res_data, res_id, busy, req_ready);
    end
    arst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[0 +: AW] = 8'd200;
    req_b[0 +: BW] = 8'hFD;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_grant: ready=%b, required 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_latency1: valid=%b busy=%b, required 0 1", res_valid, busy);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'hFFFD || res_id !== 2'd0) begin
      errors++; $display("FAIL single_result: valid=%b data=%h id=%0d, required 1 fffd 0", res_valid, res_data, res_id);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_drain: valid=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [OW-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = 8'd200;
      req_b[i*BW +: BW] = BW'(-32 * (i + 1));
    end
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          errors++; $display("FAIL rr_grant c=%0d: ready=%b, required %b", c, req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 2) begin
        exp_d = OW'(-25 * ((c - 2) % 4 + 1));
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'((c - 2) % 4) || res_data !== exp_d) begin
          errors++; $display("FAIL rr_result c=%0d: valid=%b id=%0d data=%h, required 1 %0d %h",
                             c, res_valid, res_id, res_data, (c - 2) % 4, exp_d);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] exp_tab [6] = '{16'd3, 16'd7, 16'd11, 16'd15, 16'd19, 16'd23};
    apply_reset();
    res_ready = 1'b1;
    req_a[2*AW +: AW] = 8'd100;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) begin
        req_valid = 4'b0100;
        req_b[2*BW +: BW] = BW'(10 * (c + 1));
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (c < 6) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL stream_grant c=%0d: ready=%b, required 0100", c, req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd2 || res_data !== exp_tab[c-2]) begin
          errors++; $display("FAIL stream_result c=%0d: valid=%b id=%0d data=%0d, required 1 2 %0d",
                             c, res_valid, res_id, res_data, exp_tab[c-2]);
        end
      end
      tick();
    end
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = 8'd200;
      req_b[i*BW +: BW] = BW'(-32 * (i + 1));
    end
    res_ready = 1'b1;
    req_valid = 4'b1111;
    tick(); tick();
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0 || res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== 16'hFFE7 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold k=%0d: ready=%b valid=%b id=%0d data=%h busy=%b, required 0000 1 0 ffe7 1",
                           k, req_ready, res_valid, res_id, res_data, busy);
      end
      tick();
    end
    res_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      #1;
      if (r == 0) begin
        checks++;
        if (req_ready !== 4'b0100) begin
          errors++; $display("FAIL stall_resume_grant: ready=%b, required 0100", req_ready);
        end
      end
      exp_d = OW'(-25 * (r % 4 + 1));
      checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(r % 4) || res_data !== exp_d) begin
        errors++; $display("FAIL stall_resume r=%0d: valid=%b id=%0d data=%h, required 1 %0d %h",
                           r, res_valid, res_id, res_data, r % 4, exp_d);
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_wrap_sat();
    logic [7:0] va [3] = '{8'd255, 8'd255, 8'd3};
    logic [7:0] vb [3] = '{8'd127, 8'hFF, 8'hFB};
`ifdef MUL_ARB_RESULT_SAT_EN
    logic [7:0] vexp [3] = '{8'h7F, 8'h80, 8'hF1};
    logic       vsat [3] = '{1'b1, 1'b1, 1'b0};
`else
    logic [7:0] vexp [3] = '{8'h81, 8'h01, 8'hF1};
`endif
    apply_reset();
    w_res_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      w_req_valid = 4'b0001;
      w_req_a[0 +: AW] = va[v];
      w_req_b[0 +: BW] = vb[v];
      #1;
      checks++;
      if (w_req_ready !== 4'b0001) begin
        errors++; $display("FAIL wrap_grant v=%0d: ready=%b, required 0001", v, w_req_ready);
      end
      tick();
      w_req_valid = '0;
      tick();
      checks++;
      if (w_res_valid !== 1'b1 || w_res_data !== vexp[v]) begin
        errors++; $display("FAIL wrap_result v=%0d: valid=%b data=%h, required 1 %h", v, w_res_valid, w_res_data, vexp[v]);
      end
`ifdef MUL_ARB_RESULT_SAT_EN
      checks++;
      if (w_res_sat !== vsat[v]) begin
        errors++; $display("FAIL sat_flag v=%0d: res_sat=%b, required %b", v, w_res_sat, vsat[v]);
      end
`endif
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    res_ready = 1'b1;
    req_valid = 4'b1010;
    tick(); tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_fill: valid=%b id=%0d busy=%b, required 1 1 1", res_valid, res_id, busy);
    end
    req_valid = '0;
    arst_n_in = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async: valid=%b busy=%b, required 0 0", res_valid, busy);
    end
    tick();
    arst_n_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_stale k=%0d: valid=%b, required 0", k, res_valid);
      end
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_first_grant: ready=%b, required 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1) begin
      errors++; $display("FAIL midrst_result: valid=%b id=%0d, required 1 1", res_valid, res_id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_wrap_sat();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
